// File: rtl/interval_scheduler_if.sv
// Bundle between the requesting FSMs / datapath and the interval scheduler.
// The slave modport is the scheduler's view; master is the environment driving it.
interface interval_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 13
);
  logic [NREQ-1:0]    req;
  logic [NREQ*CW-1:0] dur;
  logic               abort;
  logic [CW-1:0]      cnt;
  logic               dp_clr;
  logic               dp_en;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;

  modport slave (
    input  req, dur, abort, cnt,
    output dp_clr, dp_en, gnt, done, busy
  );

  modport master (
    output req, dur, abort, cnt,
    input  dp_clr, dp_en, gnt, done, busy
  );
endinterface

// File: rtl/interval_scheduler.sv
// Round-robin arbiter that lends one clear/enable tick-counter datapath to NREQ requesters
// and pulses done to the owner once the counter reaches its latched interval.
module interval_scheduler #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 13
) (
  input logic                clk,
  input logic                rst,
  interval_scheduler_if.slave bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StRun   = 3'd2,
    StDone  = 3'd3,
    StAbort = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [CW-1:0]   target_q, target_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   last_q, last_d;

  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            own_req;

  // Search upward from the slot after the last owner, so the last owner is considered last.
  always_comb begin
    int unsigned j;
    pick_valid = 1'b0;
    pick_idx   = '0;
    j          = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      j = (32'(last_q) + k) % NREQ;
      if (bus.req[IW'(j)] && !pick_valid) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(j);
      end
    end
  end

  assign own_req = |(bus.req & gnt_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    target_d = target_q;
    owner_d  = owner_q;
    last_d   = last_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d    = NREQ'(1) << pick_idx;
          owner_d  = pick_idx;
          target_d = bus.dur[32'(pick_idx) * CW +: CW];
          state_d  = (bus.dur[32'(pick_idx) * CW +: CW] == '0) ? StDone : StClear;
        end
      end
      StClear: state_d = StRun;
      StRun: begin
        // Abort has priority over a simultaneous completion.
        if (bus.abort || !own_req) begin
          state_d = StAbort;
        end else if (bus.cnt >= target_q) begin
          state_d = StDone;
        end
      end
      StDone, StAbort: begin
        last_d  = owner_q;
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      target_q <= '0;
      owner_q  <= '0;
      last_q   <= IW'(NREQ - 1);
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      target_q <= target_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    bus.dp_en  = (state_q == StRun);
    bus.dp_clr = (state_q != StRun);
    bus.busy   = (state_q != StIdle);
    bus.gnt    = gnt_q;
    bus.done   = (state_q == StDone) ? gnt_q : '0;
  end

endmodule
